// File: rtl/rr_arb_4to1_pkg.sv
// Shared encodings for the 4:1 round-robin arbiter and its mux datapath.
//   SEL_X0..SEL_X3 : mux select encodings for sources 0..3
//   ARB_EMPTY/FULL : output-register occupancy state
//   sel_onehot()   : select index -> one-hot grant vector
package rr_arb_4to1_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [SEL_W-1:0] SEL_X0 = 2'd0;
  localparam logic [SEL_W-1:0] SEL_X1 = 2'd1;
  localparam logic [SEL_W-1:0] SEL_X2 = 2'd2;
  localparam logic [SEL_W-1:0] SEL_X3 = 2'd3;

  localparam logic [0:0] ARB_EMPTY = 1'b0;
  localparam logic [0:0] ARB_FULL  = 1'b1;

  // Converts a source index into the one-hot grant pattern for that source.
  function automatic logic [NUM_SRC-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NUM_SRC'(1) << sel;
  endfunction

endpackage

// File: rtl/mux_4to1.sv
// N-bit 4:1 combinational multiplexer (datapath slice shared with the arbiter).
//   X0..X3 : input words
//   S      : select (SEL_X0..SEL_X3)
//   Z      : selected word
module mux_4to1
  import rr_arb_4to1_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     X0,
  input  logic [N-1:0]     X1,
  input  logic [N-1:0]     X2,
  input  logic [N-1:0]     X3,
  input  logic [SEL_W-1:0] S,
  output logic [N-1:0]     Z
);

  // Plain select; every encoding is covered so no latch is possible.
  always_comb begin
    Z = X0;
    unique case (S)
      SEL_X0:  Z = X0;
      SEL_X1:  Z = X1;
      SEL_X2:  Z = X2;
      SEL_X3:  Z = X3;
      default: Z = X0;
    endcase
  end

endmodule

// File: rtl/rr_arb_4to1.sv
// Registered 4-input round-robin arbiter feeding the 4:1 mux datapath.
// Picks one requesting source per free output slot, rotating priority from
// the source after the most recent grant, and presents the captured word on
// a valid/ready output register. Each capture is acknowledged by a one-cycle
// one-hot grant pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-source request (source holds Xi stable until granted)
//   X0..X3     : source words
//   out_ready  : downstream takes Z this cycle
//   grant      : one-hot pulse, source i's word was captured on this edge
//   S          : select index of the word held in Z
//   Z          : registered output word
//   out_valid  : Z holds a valid word
module rr_arb_4to1
  import rr_arb_4to1_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   req,
  input  logic [N-1:0]         X0,
  input  logic [N-1:0]         X1,
  input  logic [N-1:0]         X2,
  input  logic [N-1:0]         X3,
  input  logic                 out_ready,
  output logic [NUM_SRC-1:0]   grant,
  output logic [SEL_W-1:0]     S,
  output logic [N-1:0]         Z,
  output logic                 out_valid
);

  logic [0:0]         state_q, state_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   s_d;
  logic [N-1:0]       z_d;
  logic [NUM_SRC-1:0] grant_d;

  logic               load_c;
  logic               found_c;
  logic [SEL_W-1:0]   winner_c;
  logic [N-1:0]       mux_z_c;

  // Output slot is free when empty or being drained this cycle.
  assign load_c = (state_q == ARB_EMPTY) | out_ready;

  // Priority search: last+1, last+2, last+3, last (2-bit wrap).
  always_comb begin
    found_c  = 1'b0;
    winner_c = last_q;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      logic [SEL_W-1:0] idx;
      idx = last_q + SEL_W'(k);
      if (!found_c && req[idx]) begin
        found_c  = 1'b1;
        winner_c = idx;
      end
    end
  end

  // Capture word comes straight from the datapath mux steered by the winner.
  mux_4to1 #(
    .N (N)
  ) u_mux (
    .X0 (X0),
    .X1 (X1),
    .X2 (X2),
    .X3 (X3),
    .S  (winner_c),
    .Z  (mux_z_c)
  );

  // Next-state and output-register next values.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    s_d     = S;
    z_d     = Z;
    grant_d = '0;
    if (load_c) begin
      if (found_c) begin
        state_d = ARB_FULL;
        last_d  = winner_c;
        s_d     = winner_c;
        z_d     = mux_z_c;
        grant_d = sel_onehot(winner_c);
      end else begin
        state_d = ARB_EMPTY;
      end
    end
  end

  // State and output registers; last resets to 3 so source 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_EMPTY;
      last_q  <= SEL_X3;
      S       <= SEL_X0;
      Z       <= '0;
      grant   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      S       <= s_d;
      Z       <= z_d;
      grant   <= grant_d;
    end
  end

  assign out_valid = (state_q == ARB_FULL);

endmodule

// File: tb/tb_rr_arb_4to1.sv
// Directed bench for rr_arb_4to1: reset, rotation, skip/wrap, backpressure,
// drain and asynchronous reset in mid-stream.
module tb_rr_arb_4to1;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [N-1:0] X0, X1, X2, X3;
  logic         out_ready;
  logic [3:0]   grant;
  logic [1:0]   S;
  logic [N-1:0] Z;
  logic         out_valid;

  int tests_run;
  int tests_failed;

  rr_arb_4to1 #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .X0        (X0),
    .X1        (X1),
    .X2        (X2),
    .X3        (X3),
    .out_ready (out_ready),
    .grant     (grant),
    .S         (S),
    .Z         (Z),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the expected tuple.
  task automatic chk_all(input string tag, input logic v, input logic [3:0] g,
                         input logic [1:0] s, input logic [N-1:0] z);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".S"},     32'(S), 32'(s));
    chk({tag, ".Z"},     32'(Z), 32'(z));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    req       = 4'hF;
    out_ready = 1'b1;
    X0 = 4'd1; X1 = 4'd2; X2 = 4'd3; X3 = 4'd4;

    // 1 Reset held with all requests pending
    #2;
    chk_all("reset0", 1'b0, 4'b0000, 2'd0, 4'd0);
    step();
    chk_all("reset1", 1'b0, 4'b0000, 2'd0, 4'd0);
    step();
    chk_all("reset2", 1'b0, 4'b0000, 2'd0, 4'd0);
    rst_n = 1'b1;

    // 2 Rotation through all four sources and wrap back to 0
    step(); chk_all("rot0", 1'b1, 4'b0001, 2'd0, 4'd1);
    step(); chk_all("rot1", 1'b1, 4'b0010, 2'd1, 4'd2);
    step(); chk_all("rot2", 1'b1, 4'b0100, 2'd2, 4'd3);
    step(); chk_all("rot3", 1'b1, 4'b1000, 2'd3, 4'd4);
    step(); chk_all("rot4", 1'b1, 4'b0001, 2'd0, 4'd1);

    // 3 Skip/wrap: park last at 2, then only sources 0,1 request
    req = 4'b0100;
    step(); chk_all("park2", 1'b1, 4'b0100, 2'd2, 4'd3);
    req = 4'b0011;
    step(); chk_all("wrap0", 1'b1, 4'b0001, 2'd0, 4'd1);
    step(); chk_all("wrap1", 1'b1, 4'b0010, 2'd1, 4'd2);
    step(); chk_all("wrap2", 1'b1, 4'b0001, 2'd0, 4'd1);

    // Single requester is granted on every load cycle
    req = 4'b0001;
    X0  = 4'd9;
    step(); chk_all("single", 1'b1, 4'b0001, 2'd0, 4'd9);

    // 4 Backpressure: Z=9 held, req changes ignored
    out_ready = 1'b0;
    req = 4'b0110;
    step(); chk_all("bp0", 1'b1, 4'b0000, 2'd0, 4'd9);
    req = 4'b1000;
    step(); chk_all("bp1", 1'b1, 4'b0000, 2'd0, 4'd9);
    req = 4'b0110;
    step(); chk_all("bp2", 1'b1, 4'b0000, 2'd0, 4'd9);
    out_ready = 1'b1;
    step(); chk_all("bp_release", 1'b1, 4'b0010, 2'd1, 4'd2);

    // 5 Drain: no requests, Z/S hold the last word
    req = 4'b0000;
    step(); chk_all("drain0", 1'b0, 4'b0000, 2'd1, 4'd2);
    out_ready = 1'b0;
    step(); chk_all("drain1", 1'b0, 4'b0000, 2'd1, 4'd2);

    // Empty slot loads even with out_ready low; last=1 so source 2 wins
    req = 4'hF;
    step(); chk_all("fill", 1'b1, 4'b0100, 2'd2, 4'd3);

    // 6 Asynchronous reset while FULL
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 4'b0000, 2'd0, 4'd0);
    step();
    rst_n = 1'b1;
    req = 4'b1001;
    out_ready = 1'b1;
    step(); chk_all("post_rst", 1'b1, 4'b0001, 2'd0, 4'd9);
    step(); chk_all("post_rst1", 1'b1, 4'b1000, 2'd3, 4'd4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
